// File: rtl/spi_slave_phy.sv
// SPI slave physical layer: synchronizes the SPI pins into clk, emits one pulse per
// sampled MOSI bit and shifts im_tx_data out on MISO, LSB first, for any CPOL/CPHA.
module spi_slave_phy #(
  parameter bit CPOL = 1'b0,
  parameter bit CPHA = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       im_sclk,
  input  logic       im_cs_n,
  input  logic       im_mosi,
  input  logic [7:0] im_tx_data,
  output logic       om_miso,
  output logic       om_work_en,
  output logic       om_work_pluse,
  output logic       om_data,
  output logic       om_tx_req,
  output logic       om_frame_err
);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t     state, state_d;
  logic [2:0] sclk_q, cs_q, mosi_q;
  logic [2:0] bit_cnt, bit_cnt_d;
  logic [7:0] tx_shift, tx_shift_d;
  logic       pulse_d, data_d, tx_req_d, ferr_d;
  logic       sclk_rise, sclk_fall, lead_edge, trail_edge;
  logic       sample_edge, shift_edge, cs_lo, cs_hi;

  // [0],[1] = synchronizer, [2] = history; all three chains have equal depth
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q <= {3{CPOL}};
      cs_q   <= '1;
      mosi_q <= '0;
    end else begin
      sclk_q <= {sclk_q[1:0], im_sclk};
      cs_q   <= {cs_q[1:0], im_cs_n};
      mosi_q <= {mosi_q[1:0], im_mosi};
    end
  end

  assign sclk_rise   = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall   = ~sclk_q[1] & sclk_q[2];
  assign lead_edge   = CPOL ? sclk_fall : sclk_rise;
  assign trail_edge  = CPOL ? sclk_rise : sclk_fall;
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;

  // CS must hold a level for two synchronized samples, so a one-clk glitch is ignored
  assign cs_lo = ~cs_q[1] & ~cs_q[2];
  assign cs_hi = cs_q[1] & cs_q[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      tx_shift      <= '0;
      om_work_pluse <= 1'b0;
      om_data       <= 1'b0;
      om_tx_req     <= 1'b0;
      om_frame_err  <= 1'b0;
    end else begin
      state         <= state_d;
      bit_cnt       <= bit_cnt_d;
      tx_shift      <= tx_shift_d;
      om_work_pluse <= pulse_d;
      om_data       <= data_d;
      om_tx_req     <= tx_req_d;
      om_frame_err  <= ferr_d;
    end
  end

  always_comb begin
    state_d    = state;
    bit_cnt_d  = bit_cnt;
    tx_shift_d = tx_shift;
    pulse_d    = 1'b0;
    data_d     = om_data;
    tx_req_d   = 1'b0;
    ferr_d     = 1'b0;
    case (state)
      IDLE: begin
        if (cs_lo) begin
          state_d    = ACTIVE;
          tx_shift_d = im_tx_data;
          tx_req_d   = 1'b1;
          bit_cnt_d  = '0;
        end
      end
      ACTIVE: begin
        if (cs_hi) begin
          state_d   = IDLE;
          ferr_d    = (bit_cnt != 3'd0);
          bit_cnt_d = '0;
        end else if (sample_edge) begin
          pulse_d   = 1'b1;
          data_d    = mosi_q[2];
          bit_cnt_d = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            tx_shift_d = im_tx_data;
            tx_req_d   = 1'b1;
          end
        end else if (shift_edge && bit_cnt != 3'd0) begin
          // bit_cnt==0 marks a freshly loaded byte whose bit 0 is already on MISO
          tx_shift_d = {1'b0, tx_shift[7:1]};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign om_work_en = (state == ACTIVE);
  assign om_miso    = (state == ACTIVE) & tx_shift[0];

endmodule

// File: doc/spi_slave_phy.md
SPI_SLAVE_PHY -- requirements
Module: spi_slave_phy

Interface
REQ-001 Parameter CPOL, default 0, SCLK idle level.
REQ-002 Parameter CPHA, default 0; 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-003 clk  input  1  system clock; must be at least 8x SCLK frequency.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 im_sclk  input  1  SPI clock pin, asynchronous to clk.
REQ-006 im_cs_n  input  1  SPI chip select pin, active-low, asynchronous.
REQ-007 im_mosi  input  1  SPI data-in pin, asynchronous.
REQ-008 im_tx_data  input  8  byte to shift out on MISO.
REQ-009 om_miso  output  1  SPI data-out pin.
REQ-010 om_work_en  output  1  high while the synchronized CS is active; drives the byte receiver's enable.
REQ-011 om_work_pluse  output  1  one-clk pulse per sampled MOSI bit.
REQ-012 om_data  output  1  sampled MOSI bit; valid when om_work_pluse=1.
REQ-013 om_tx_req  output  1  one-clk pulse when im_tx_data has been latched.
REQ-014 om_frame_err  output  1  one-clk pulse when CS deasserts mid-byte.

Function
REQ-015 SCLK, CS_n and MOSI each pass through a 2-flop synchronizer plus one history flop; all three chains have equal depth, so MOSI stays aligned to SCLK.
REQ-016 Leading edge = rising if CPOL=0, falling if CPOL=1; trailing edge = the opposite edge.
REQ-017 Sample edge = leading if CPHA=0, trailing if CPHA=1; shift edge = the other edge.
REQ-018 Edges are detected from synchronized SCLK only while the synchronized CS is active; SCLK edges while CS is inactive are ignored.
REQ-019 State machine: IDLE (CS inactive) and ACTIVE; IDLE->ACTIVE on synchronized CS falling; ACTIVE->IDLE on synchronized CS rising.
REQ-020 om_work_en is registered: 1 in ACTIVE, 0 in IDLE.
REQ-021 On each sample edge in ACTIVE: om_work_pluse=1 for exactly one clk, and om_data=synchronized MOSI.
REQ-022 Latency: om_work_pluse asserts on the 3rd clk edge after the first clk edge that samples the new SCLK level.
REQ-023 Bit order is LSB first in both directions; the 3-bit bit counter increments on each sample edge and wraps 7->0.
REQ-024 On IDLE->ACTIVE: latch im_tx_data into the tx shift register, pulse om_tx_req, and reset the bit counter to 0.
REQ-025 MISO bit order and timing:
- om_miso = tx_shift[0] during ACTIVE.
- The register shifts right on each shift edge, except the shift edge that precedes any sample (CPHA=1 first edge).
REQ-026 When the bit counter wraps 7->0 on a sample edge, reload tx_shift from im_tx_data on that same clk and pulse om_tx_req, so back-to-back bytes stream without gaps.
REQ-027 om_miso = 0 in IDLE.
REQ-028 On ACTIVE->IDLE with bit counter != 0: pulse om_frame_err for one clk, clear the bit counter, and keep om_work_pluse low.
REQ-029 A CS rising edge and a sample edge in the same clk: the sample edge is dropped, and the CS rise wins.
REQ-030 om_work_pluse and om_tx_req never assert in IDLE.
REQ-031 A CS pulse shorter than 2 clk may be missed; it produces no output pulses and no error.

Reset
REQ-032 Asynchronous reset while rst_n=0 forces:
- all synchronizer flops to their idle values (sclk=CPOL, cs_n=1, mosi=0);
- state IDLE and bit counter 0;
- tx_shift=0;
- all outputs 0.
REQ-033 Reset asserted mid-byte aborts the frame with no om_frame_err; after release the block waits in IDLE for a fresh CS falling edge.

Verification
REQ-034 Mode 0, CS low, MOSI byte 0xA5 LSB first, 8 SCLK cycles:
- 8 om_work_pluse pulses carrying om_data 1,0,1,0,0,1,0,1;
- om_work_en high throughout.
REQ-035 Mode 0, im_tx_data=0x3C at CS fall: om_miso sampled at each SCLK rising edge gives 0,0,1,1,1,1,0,0, and om_tx_req pulses once at CS fall.
REQ-036 Mode 3 (CPOL=1, CPHA=1), two back-to-back bytes 0x01 then 0x80 on both MOSI and im_tx_data:
- 16 pulses with correct bits;
- om_tx_req pulses at CS fall and after bit 7;
- MISO returns 0x01, then 0x80.
REQ-037 CS rises after 5 bits: om_frame_err pulses once, and om_work_en falls; the next frame starts at bit counter 0.
REQ-038 SCLK toggled 4 times with CS high: no om_work_pluse, and om_miso=0.
REQ-039 rst_n asserted after 3 bits then released, followed by a full 0xFF frame: exactly 8 pulses, all om_data=1, and no om_frame_err.
